fifo_sync_cfg: RTL
==================

Name: fifo_sync_cfg

Overview:
Parametrised successor to the basic synchronous FIFO, with any depth, selectable read mode and configurable thresholds.
- Read modes: first-word-fall-through (FWFT) or registered read.
- Adds programmable almost-full/almost-empty flags, synchronous flush, clearable sticky error flags and a peak-occupancy register.
- Used between the Basys3 wrapper peripherals (UART, debug) and the CPU bus.

Parameters:
DATA_W, 8, payload width in bits (>=1)
ENTRIES, 12, usable storage slots (>=2); full means exactly ENTRIES words held
FWFT, 1, 1 = read_data shows head word combinationally; 0 = one-cycle registered read
AFULL_THRESH, ENTRIES-2, almost_full when count >= value (1..ENTRIES)
AEMPTY_THRESH, 2, almost_empty when count <= value (0..ENTRIES-1)
Derived: PTR_W = max(1,$clog2(ENTRIES)); CNT_W = $clog2(ENTRIES+1). Illegal values raise an elaboration-time $error.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all contents (synchronous)
write_en  in  1  write request
write_data  in  DATA_W  write payload
full  out  1  count == ENTRIES
almost_full  out  1  count >= AFULL_THRESH
read_en  in  1  read request / pop
read_data  out  DATA_W  head word (FWFT) or registered popped word
read_valid  out  1  FWFT: !empty; registered: popped word valid this cycle
empty  out  1  count == 0
almost_empty  out  1  count <= AEMPTY_THRESH
status_count  out  CNT_W  current occupancy
status_peak  out  CNT_W  maximum occupancy since reset or status_clear
status_overflow  out  1  sticky: write_en while full
status_underflow  out  1  sticky: read_en while empty
status_clear  in  1  clear sticky flags and peak

Behaviour:
- Reset values: count 0, empty 1, full 0, almost_full 0, almost_empty 1, peak 0, both sticky flags 0, pointers 0, read_valid 0, registered read_data 0.
- Storage array is not reset. In FWFT mode read_data is undefined while read_valid=0.
- Occupancy comes from the count register. Full, empty and the almost flags are combinational decodes of count.
- wr_xfer = write_en & !full & !flush. rd_xfer = read_en & !empty & !flush. full/empty are sampled in the current cycle.
- Write while full: dropped even if a read happens the same cycle. Read while empty: rejected even if a write happens the same cycle. No bypass path.
- Count: +1 on wr_xfer only, -1 on rd_xfer only, unchanged on both or neither.
- Pointers wrap from ENTRIES-1 to 0. ENTRIES need not be a power of two.
- FWFT=1: read_data = mem[rd_ptr]. The pop takes effect on the edge where rd_xfer is high, and the next head word is visible the following cycle.
- FWFT=0: on rd_xfer, read_data <= mem[rd_ptr] and read_valid <= 1. Otherwise read_valid <= 0 and read_data holds its value. Latency is 1 cycle.
- Flush has priority over read and write. Next cycle: pointers 0, count 0, registered read_valid 0.
  - A write or read in the flush cycle is ignored and does not set the sticky flags.
  - Flush does not clear peak or the sticky flags.
- Sticky flags: set on write_en & full & !flush, or read_en & empty & !flush. status_clear clears them, but a same-cycle set event wins (flag stays 1).
- status_peak <= max(peak, next_count) each cycle, so peak >= count always.
  - status_clear loads next_count, not 0.
- Reset has priority over everything. Reset mid-operation returns to reset values on the next edge; stored contents are lost.

Decomposition:
- Package fifo_cfg_pkg: parameter-legality check functions and a width helper cnt_w(entries).
- Sub-module fifo_wrap_ptr (PTR_W-bit pointer with increment, clear and non-power-of-two wrap) is instantiated twice.
- Storage, count, flags and read-mode logic live in the top level.

Test Plan:
1. ENTRIES=5, AFULL=4, FWFT=1.
   - Write 0x11..0x55: almost_full asserts after the 4th write, full after the 5th.
   - A 6th write of 0x66 is dropped and status_overflow=1 next cycle.
   - Reads return 0x11..0x55 in order; then empty=1.
2. Wrap stress, ENTRIES=5: seven rounds of write 3 / read 3 (values 0x00..0x14).
   - Data order is preserved across pointer wrap; count ends at 0 and peak=3.
3. Full with simultaneous read_en+write_en (0x99): head popped, 0x99 dropped, count 5->4, overflow set.
   - Empty with both: write accepted, underflow set, count 0->1.
4. FWFT=0: write 0xA5, then read_en one cycle later.
   - read_valid=1 and read_data=0xA5 exactly one cycle after read_en; read_valid=0 the cycle after.
5. Count=3, then flush+write_en(0x77) in the same cycle.
   - Next cycle: count 0, empty 1, 0x77 absent, no overflow, peak still 3.
   - status_clear then gives peak 0.
6. status_clear coincident with read_en on empty: status_underflow stays 1.
   - reset asserted with count 4: next cycle all outputs at reset values.

Source files
------------

// File: rtl/fifo_cfg_pkg.sv
// fifo_cfg_pkg: width helpers and parameter legality checks for fifo_sync_cfg
package fifo_cfg_pkg;
  function automatic int cnt_w(input int entries);
    return $clog2(entries + 1);
  endfunction
  function automatic int ptr_w(input int entries);
    return entries > 2 ? $clog2(entries) : 1;
  endfunction
  function automatic bit params_ok(input int data_w, input int entries, input int fwft, input int afull, input int aempty);
    return data_w >= 1 && entries >= 2 && (fwft == 0 || fwft == 1) && afull >= 1 && afull <= entries && aempty >= 0 && aempty <= entries - 1;
  endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: storage pointer that wraps at ENTRIES-1, for any depth
module fifo_wrap_ptr #(
  parameter int ENTRIES = 12,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);
  // advance on inc, wrapping explicitly so non-power-of-two depths work
  always_ff @(posedge clk)
    ptr <= (reset || clear) ? '0 : !inc ? ptr : (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + PTR_W'(1);
endmodule

// File: rtl/fifo_sync_cfg.sv
// fifo_sync_cfg: configurable synchronous FIFO with FWFT/registered read and status
module fifo_sync_cfg
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ENTRIES = 12,
  parameter int FWFT = 1,
  parameter int AFULL_THRESH = ENTRIES - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int PTR_W = ptr_w(ENTRIES),
  localparam int CNT_W = cnt_w(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic              full,
  output logic              almost_full,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  status_count,
  output logic [CNT_W-1:0]  status_peak,
  output logic              status_overflow,
  output logic              status_underflow,
  input  logic              status_clear
);
  if (!params_ok(DATA_W, ENTRIES, FWFT, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("fifo_sync_cfg: illegal parameter combination");
  end
  logic [DATA_W-1:0] mem [ENTRIES];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  next_count;
  logic              wr_xfer, rd_xfer;
  // flags are pure decodes of the occupancy register
  always_comb begin
    full = status_count == CNT_W'(ENTRIES);
    empty = status_count == '0;
    almost_full = status_count >= CNT_W'(AFULL_THRESH);
    almost_empty = status_count <= CNT_W'(AEMPTY_THRESH);
    wr_xfer = write_en && !full && !flush;
    rd_xfer = read_en && !empty && !flush;
    next_count = flush ? '0 : (wr_xfer && !rd_xfer) ? status_count + CNT_W'(1) : (rd_xfer && !wr_xfer) ? status_count - CNT_W'(1) : status_count;
  end
  fifo_wrap_ptr #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_wr_ptr (
    .clk(clk), .reset(reset), .clear(flush), .inc(wr_xfer), .ptr(wr_ptr)
  );
  fifo_wrap_ptr #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_rd_ptr (
    .clk(clk), .reset(reset), .clear(flush), .inc(rd_xfer), .ptr(rd_ptr)
  );
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (wr_xfer) mem[wr_ptr] <= write_data;
  // occupancy, peak tracking and sticky error flags; a set event beats a clear
  always_ff @(posedge clk) begin
    status_count <= reset ? '0 : next_count;
    status_peak <= reset ? '0 : (status_clear || next_count > status_peak) ? next_count : status_peak;
    status_overflow <= !reset && ((write_en && full && !flush) || (status_overflow && !status_clear));
    status_underflow <= !reset && ((read_en && empty && !flush) || (status_underflow && !status_clear));
  end
  if (FWFT != 0) begin : g_fwft
    assign read_data = mem[rd_ptr];
    assign read_valid = !empty;
  end else begin : g_reg
    // registered read: capture the popped word and pulse valid for one cycle
    always_ff @(posedge clk) begin
      read_valid <= !reset && rd_xfer;
      read_data <= reset ? '0 : rd_xfer ? mem[rd_ptr] : read_data;
    end
  end
endmodule
